// File: rtl/hlatch_tx_if.sv
// -----------------------------------------------------------------------------
// hlatch_tx_if
//   Bundle of the two channels around the hlatch_tx transmitter:
//     - synchronous valid/ready word stream on the clocked side
//     - four-phase bundled-data channel into the first async latch stage
//
// Signals
//   s_valid  upstream word available
//   s_ready  transmitter FIFO can accept a word
//   s_data   upstream word, N bits
//   r_o      four-phase request into the async stage
//   a_o      acknowledge from the async stage (asynchronous to clk)
//   d_o      bundled data, N bits
//
// Modports
//   slave   the transmitter itself
//   master  the surrounding environment (stream source + async stage)
// -----------------------------------------------------------------------------
interface hlatch_tx_if #(
  parameter int N = 1
);
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_data;
  logic         r_o;
  logic         a_o;
  logic [N-1:0] d_o;

  modport slave (
    input  s_valid,
    input  s_data,
    input  a_o,
    output s_ready,
    output r_o,
    output d_o
  );

  modport master (
    output s_valid,
    output s_data,
    output a_o,
    input  s_ready,
    input  r_o,
    input  d_o
  );
endinterface

// File: rtl/hlatch_tx.sv
// -----------------------------------------------------------------------------
// hlatch_tx
//   Clocked transmitter feeding a four-phase bundled-data asynchronous latch
//   pipeline. Words arrive on a valid/ready stream, are buffered in a small
//   FIFO, and are presented on d_o with a request r_o. The acknowledge a_o is
//   brought into the clock domain through a SYNC_STAGES flop synchronizer and
//   only the synchronized copy steers the handshake FSM.
//
// Parameters
//   N             data width
//   DEPTH         FIFO entries (power of two, >= 2)
//   SYNC_STAGES   flops in the a_o synchronizer (>= 2)
//   SETUP_CYCLES  edges d_o is held before r_o rises (>= 1)
//
// Ports
//   clk     the only clock, rising edge
//   rst     asynchronous, active-low reset
//   bus     hlatch_tx_if.slave: s_valid/s_ready/s_data stream in,
//           r_o/a_o/d_o four-phase channel out
//   count   FIFO occupancy, excluding the word currently on d_o
// -----------------------------------------------------------------------------
module hlatch_tx #(
  parameter int N            = 1,
  parameter int DEPTH        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int SETUP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  hlatch_tx_if.slave            bus,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    RTZ   = 2'd3
  } state_t;

  state_t                 state;
  logic [SW-1:0]          setup_cnt;
  logic                   r_q;
  logic [N-1:0]           d_q;

  logic [SYNC_STAGES-1:0] a_sync;
  logic                   a_s;

  logic [N-1:0]           mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   ready;
  logic                   empty;
  logic                   push;
  logic                   take;

  // ---------------------------------------------------------------------------
  // Acknowledge synchronizer: a_s is a_o after SYNC_STAGES flops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], bus.a_o};
    end
  end

  assign a_s = a_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FIFO control. s_ready depends on count only, so there is no combinational
  // path from s_valid or a_o to any output. When full, s_ready is low, so a
  // same-edge pop never collides with a push into the slot being read.
  // ---------------------------------------------------------------------------
  assign ready = (count != CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.s_valid & ready;

  // The FSM takes a word from IDLE or from the end of RTZ, both only once the
  // synchronized acknowledge is low again.
  assign take  = ~empty & ~a_s & ((state == IDLE) | (state == RTZ));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH by themselves.
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (take) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, take})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Four-phase handshake FSM with registered r_o/d_o.
  // d_o is written only on a take, so it is stable from SETUP entry through
  // REQ and RTZ until the next word is taken.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      setup_cnt <= '0;
      r_q       <= 1'b0;
      d_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          r_q <= 1'b0;
          if (take) begin
            d_q       <= mem[rd_ptr];
            setup_cnt <= '0;
            state     <= SETUP;
          end
        end

        SETUP: begin
          // The a_s guard keeps a stray acknowledge from ever overlapping a
          // fresh request; the counter simply holds at its terminal value.
          if (setup_cnt == SW'(SETUP_CYCLES - 1)) begin
            if (!a_s) begin
              r_q   <= 1'b1;
              state <= REQ;
            end
          end else begin
            setup_cnt <= setup_cnt + SW'(1);
          end
        end

        REQ: begin
          if (a_s) begin
            r_q   <= 1'b0;
            state <= RTZ;
          end
        end

        RTZ: begin
          r_q <= 1'b0;
          if (!a_s) begin
            if (take) begin
              d_q       <= mem[rd_ptr];
              setup_cnt <= '0;
              state     <= SETUP;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          r_q   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready = ready;
  assign bus.r_o     = r_q;
  assign bus.d_o     = d_q;

endmodule

// File: tb/tb_hlatch_tx.sv
// -----------------------------------------------------------------------------
// tb_hlatch_tx
//   Two transmitters share clk/rst: u_a with the default setup margin and u_b
//   with SETUP_CYCLES=3. Each has its own auto-acknowledging async stage and a
//   queue-based reference: every accepted word is appended, and every rising
//   r_o must present the oldest outstanding word on d_o.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hlatch_tx;

  localparam int N       = 8;
  localparam int DEPTH   = 4;
  localparam int SYNC    = 2;
  localparam int SETUP_A = 1;
  localparam int SETUP_B = 3;
  localparam int CW      = $clog2(DEPTH) + 1;

  typedef logic [N-1:0] word_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hlatch_tx_if #(.N(N)) bus_a ();
  hlatch_tx_if #(.N(N)) bus_b ();
  logic [CW-1:0] count_a;
  logic [CW-1:0] count_b;

  hlatch_tx #(.N(N), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .SETUP_CYCLES(SETUP_A)) u_a (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus_a),
    .count (count_a)
  );

  hlatch_tx #(.N(N), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .SETUP_CYCLES(SETUP_B)) u_b (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus_b),
    .count (count_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference queues of words accepted but not yet requested downstream.
  word_t q_a[$];
  word_t q_b[$];

  // Async-stage models: follow r_o after a (possibly random) delay.
  bit stall_a = 1'b0;
  bit stall_b = 1'b0;
  int lat_min = 1;
  int lat_max = 1;
  int cnt_a = 0, lat_a = 1;
  int cnt_b = 0, lat_b = 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_a.a_o <= 1'b0;
      cnt_a     <= 0;
    end else if (stall_a) begin
      cnt_a <= 0;
    end else if (bus_a.r_o != bus_a.a_o) begin
      if (cnt_a >= lat_a) begin
        bus_a.a_o <= bus_a.r_o;
        cnt_a     <= 0;
        lat_a     <= int'($urandom_range(lat_max, lat_min));
      end else begin
        cnt_a <= cnt_a + 1;
      end
    end else begin
      cnt_a <= 0;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_b.a_o <= 1'b0;
      cnt_b     <= 0;
    end else if (stall_b) begin
      cnt_b <= 0;
    end else if (bus_b.r_o != bus_b.a_o) begin
      if (cnt_b >= lat_b) begin
        bus_b.a_o <= bus_b.r_o;
        cnt_b     <= 0;
        lat_b     <= int'($urandom_range(lat_max, lat_min));
      end else begin
        cnt_b <= cnt_b + 1;
      end
    end else begin
      cnt_b <= 0;
    end
  end

  // Bench-side view of the synchronized acknowledge: a_o delayed SYNC edges.
  logic [SYNC-1:0] as_m_a, as_m_b;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      as_m_a <= '0;
      as_m_b <= '0;
    end else begin
      as_m_a <= {as_m_a[SYNC-2:0], bus_a.a_o};
      as_m_b <= {as_m_b[SYNC-2:0], bus_b.a_o};
    end
  end

  // Monitors: order on each request rise, and d_o frozen while busy.
  logic  r_prev_a = 1'b0, busy_prev_a = 1'b0;
  word_t d_prev_a = '0;
  logic  r_prev_b = 1'b0, busy_prev_b = 1'b0;
  word_t d_prev_b = '0;
  int    stab_b   = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus_a.r_o && !r_prev_a) begin
        if (q_a.size() == 0) chk("a_spurious_req", 32'd1, 32'd0);
        else                 chk("a_word_order", 32'(bus_a.d_o), 32'(q_a.pop_front()));
      end
      if (bus_a.d_o != d_prev_a) chk("a_d_o_changed_while_busy", 32'(busy_prev_a), 32'd0);
    end
    r_prev_a    <= bus_a.r_o;
    d_prev_a    <= bus_a.d_o;
    busy_prev_a <= bus_a.r_o | as_m_a[SYNC-1];
  end

  always @(negedge clk) begin
    if (rst) begin
      if (bus_b.r_o && !r_prev_b) begin
        if (q_b.size() == 0) chk("b_spurious_req", 32'd1, 32'd0);
        else                 chk("b_word_order", 32'(bus_b.d_o), 32'(q_b.pop_front()));
        // Edges d_o has been stable up to and including the rising r_o edge.
        chk("b_setup_margin", 32'(stab_b + 1 >= SETUP_B), 32'd1);
      end
      if (bus_b.d_o != d_prev_b) chk("b_d_o_changed_while_busy", 32'(busy_prev_b), 32'd0);
    end
    stab_b      <= (bus_b.d_o != d_prev_b) ? 0 : stab_b + 1;
    r_prev_b    <= bus_b.r_o;
    d_prev_b    <= bus_b.d_o;
    busy_prev_b <= bus_b.r_o | as_m_b[SYNC-1];
  end

  task automatic push(input bit sel, input word_t w);
    int t = 0;
    if (sel) begin bus_b.s_valid = 1'b1; bus_b.s_data = w; end
    else     begin bus_a.s_valid = 1'b1; bus_a.s_data = w; end
    while (!(sel ? bus_b.s_ready : bus_a.s_ready) && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) begin
      chk("push_timeout", 32'd0, 32'd1);
    end else begin
      tick();
      if (sel) q_b.push_back(w);
      else     q_a.push_back(w);
    end
    if (sel) bus_b.s_valid = 1'b0;
    else     bus_a.s_valid = 1'b0;
  endtask

  task automatic drain(input bit sel);
    int t = 0;
    bit done = 1'b0;
    while (!done && t < 3000) begin
      if (sel) done = (q_b.size() == 0) && !bus_b.r_o && !bus_b.a_o && (count_b == '0);
      else     done = (q_a.size() == 0) && !bus_a.r_o && !bus_a.a_o && (count_a == '0);
      if (!done) begin
        tick();
        t++;
      end
    end
    if (!done) chk(sel ? "b_drain_timeout" : "a_drain_timeout", 32'd0, 32'd1);
    repeat (SYNC + 3) tick();
  endtask

  task automatic wait_a_o(input logic lvl);
    int t = 0;
    while (bus_a.a_o !== lvl && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) chk("a_o_wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #400000;
    chk("global_timeout", 32'd0, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    bus_a.s_valid = 1'b1; bus_a.s_data = 8'hFF;
    bus_b.s_valid = 1'b1; bus_b.s_data = 8'hFF;

    // Reset held with a word offered: nothing may be accepted or requested.
    repeat (3) tick();
    chk("rst_r_o_a",     32'(bus_a.r_o),     32'd0);
    chk("rst_d_o_a",     32'(bus_a.d_o),     32'd0);
    chk("rst_count_a",   32'(count_a),       32'd0);
    chk("rst_s_ready_a", 32'(bus_a.s_ready), 32'd1);
    chk("rst_r_o_b",     32'(bus_b.r_o),     32'd0);
    chk("rst_count_b",   32'(count_b),       32'd0);
    bus_a.s_valid = 1'b0;
    bus_b.s_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_r_o", 32'(bus_a.r_o | bus_b.r_o), 32'd0);
    end

    // Single word, ack 2 cycles after each r_o transition.
    push(1'b0, 8'h01);
    chk("single_count_edge0", 32'(count_a), 32'd1);
    tick();
    chk("single_d_o_edge1",   32'(bus_a.d_o), 32'h01);
    chk("single_r_o_edge1",   32'(bus_a.r_o), 32'd0);
    chk("single_count_edge1", 32'(count_a),   32'd0);
    tick();
    chk("single_r_o_edge2",   32'(bus_a.r_o), 32'd1);
    wait_a_o(1'b1);
    for (int i = 0; i < SYNC; i++) begin
      tick();
      chk("single_r_o_held", 32'(bus_a.r_o), 32'd1);
    end
    tick();
    chk("single_r_o_fall", 32'(bus_a.r_o), 32'd0);
    repeat (20) tick();
    chk("single_end_count", 32'(count_a),   32'd0);
    chk("single_end_r_o",   32'(bus_a.r_o), 32'd0);
    chk("single_end_d_o",   32'(bus_a.d_o), 32'h01);

    // Burst into a stalled stage fills the FIFO behind the in-flight word.
    stall_a = 1'b1;
    for (int i = 0; i < 5; i++) push(1'b0, word_t'(8'h0A + i));
    chk("burst_count_full", 32'(count_a),       32'd4);
    chk("burst_s_ready",    32'(bus_a.s_ready), 32'd0);
    chk("burst_d_o_head",   32'(bus_a.d_o),     32'h0A);
    chk("burst_r_o",        32'(bus_a.r_o),     32'd1);
    stall_a = 1'b0;
    drain(1'b0);
    chk("burst_count_end", 32'(count_a), 32'd0);
    chk("burst_last_word", 32'(bus_a.d_o), 32'h0E);

    // Push lands on the very edge the next word is taken at count=DEPTH-1.
    stall_a = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b0, word_t'(8'h10 + i));
    chk("simul_count_pre", 32'(count_a), 32'd3);
    stall_a = 1'b0;
    wait_a_o(1'b1);
    wait_a_o(1'b0);
    repeat (SYNC) tick();
    push(1'b0, 8'h14);
    chk("simul_count_same", 32'(count_a),   32'd3);
    chk("simul_pop_data",   32'(bus_a.d_o), 32'h11);
    for (int i = 5; i < 10; i++) push(1'b0, word_t'(8'h10 + i));
    drain(1'b0);
    chk("simul_count_end", 32'(count_a),   32'd0);
    chk("simul_last_word", 32'(bus_a.d_o), 32'h19);

    // Reset while the request is high, with one more word queued.
    stall_a = 1'b1;
    push(1'b0, 8'h33);
    push(1'b0, 8'h34);
    begin
      int t = 0;
      while (!bus_a.r_o && t < 50) begin tick(); t++; end
      if (t >= 50) chk("rst_req_wait_timeout", 32'd0, 32'd1);
    end
    tick();
    chk("rst_mid_count_pre", 32'(count_a), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_r_o",     32'(bus_a.r_o),     32'd0);
    chk("rst_mid_count",   32'(count_a),       32'd0);
    chk("rst_mid_s_ready", 32'(bus_a.s_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q_a.delete();
    q_b.delete();
    stall_a = 1'b0;
    push(1'b0, 8'h05);
    drain(1'b0);
    chk("post_rst_word",  32'(bus_a.d_o), 32'h05);
    chk("post_rst_count", 32'(count_a),   32'd0);

    // Random traffic into both transmitters with random ack latency.
    lat_min = 0;
    lat_max = 5;
    fork
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        push(1'b0, word_t'($urandom));
      end
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        push(1'b1, word_t'($urandom));
      end
    join
    drain(1'b0);
    drain(1'b1);
    chk("rand_a_outstanding", 32'(q_a.size()), 32'd0);
    chk("rand_b_outstanding", 32'(q_b.size()), 32'd0);
    chk("rand_a_count",       32'(count_a),    32'd0);
    chk("rand_b_count",       32'(count_b),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hlatch_tx.md
# hlatch_tx

Clocked transmitter for the four-phase bundled-data channel used by the asynchronous latch pipeline. It accepts words from a synchronous valid/ready stream, buffers them in a small FIFO, and drives `r_o`/`d_o` into the first asynchronous pipeline stage. It completes each transaction using a synchronized copy of the stage's acknowledge `a_o`. The block sits at the sync-to-async boundary, upstream of the first handshake latch.

## Interface
- `N`, 1: data width.
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.
- `SYNC_STAGES`, 2: flip-flops in the `a_o` synchronizer; ≥2.
- `SETUP_CYCLES`, 1: clock edges `d_o` is held stable before `r_o` rises (bundling margin); ≥1.

- `clk` input 1: the only clock; all state changes on its rising edge.
- `rst` input 1: one clock; reset is asynchronous and active-low (`rst`=0 resets).
- `s_valid` input 1: upstream word available.
- `s_ready` output 1: FIFO can accept; equals `count != DEPTH`.
- `s_data` input N: upstream word.
- `r_o` output 1: four-phase request to the async stage; registered, glitch-free.
- `a_o` input 1: acknowledge from the async stage; asynchronous to `clk`.
- `d_o` output N: bundled data; registered.
- `count` output $clog2(DEPTH)+1: FIFO occupancy; excludes the word in flight.

## Operation
- Reset (`rst`=0, asynchronous): FIFO empty, `count`=0, `s_ready`=1, `r_o`=0, `d_o`=0, synchronizer flops=0, FSM=IDLE, setup counter=0.
- `a_s` is `a_o` after `SYNC_STAGES` flops. The FSM uses only `a_s`, never raw `a_o`.
- Push: a word is written when `s_valid & s_ready` at an edge.
- Pop: the FIFO head is loaded into `d_o` when the FSM takes a word.
- Push and pop on the same edge are allowed at any occupancy, including full. When full, `s_ready`=0 that cycle, so no push occurs.
- `count` changes by +1, −1 or 0 per edge.
- Read and write pointers wrap modulo `DEPTH`.
- FSM states:
  - IDLE: `r_o`=0. If FIFO non-empty and `a_s`=0: pop head into `d_o`, clear the counter, go to SETUP.
  - SETUP: `r_o`=0, `d_o` stable. The counter increments each edge. When it reaches `SETUP_CYCLES`−1, set `r_o`<=1 and go to REQ.
  - REQ: `r_o`=1. When `a_s`=1, set `r_o`<=0 and go to RTZ.
  - RTZ: `r_o`=0. When `a_s`=0: if FIFO non-empty, pop the next word into `d_o`, clear the counter and go to SETUP; otherwise go to IDLE.
- `d_o` changes only on a pop edge. It is held from SETUP entry until the next pop, so it stays stable across the whole REQ/RTZ phase.
- The block never raises `r_o` while `a_s`=1. If `a_o` is stuck high after reset, the block waits in IDLE.
- Reset mid-transaction: `r_o` drops to 0 immediately and the in-flight word and FIFO contents are discarded. The downstream stage must be reset by the same `rst`; no recovery handshake is attempted.

## Timing
- Push at edge k into an empty FIFO with FSM in IDLE:
  - Pop and `d_o` valid after edge k+1.
  - `r_o`=1 after edge k+1+`SETUP_CYCLES`.
- `a_o` rise to `r_o` fall: `SYNC_STAGES`+1 edges after the first edge sampling `a_o`=1.
- `a_o` fall to next `d_o` load: `SYNC_STAGES`+1 edges. The next `r_o` rise follows `SETUP_CYCLES` later.
- Throughput with an immediate-ack stage: one word per 2·(`SYNC_STAGES`+1)+`SETUP_CYCLES` cycles. The FIFO absorbs upstream bursts.
- `s_ready` is combinational from `count` only; no combinational path from `s_valid` or `a_o` to any output.

## Test plan
- Reset: hold `rst`=0 with `s_valid`=1 and `a_o`=0 -> `r_o`=0, `d_o`=0, `count`=0, `s_ready`=1. Release; with no push, `r_o` stays 0 for 20 cycles.
- Single word, defaults: push 0x1 at edge 0; auto-ack model raises `a_o` 2 cycles after `r_o` rises and drops it 2 cycles after `r_o` falls.
  - `d_o`=1 after edge 1, `r_o`=1 after edge 2.
  - `r_o` falls 3 edges after `a_o` is first sampled high.
  - FSM returns to IDLE and `count`=0.
- Burst/full (`DEPTH`=4, ack stalled low): push 0xA,0xB,0xC,0xD,0xE.
  - 0xA moves to `d_o`; the FIFO holds B–E, `count`=4, `s_ready`=0.
  - Release ack -> `d_o` sequence A,B,C,D,E, one word per full four-phase cycle, no loss or reorder.
- Simultaneous push/pop at `count`=DEPTH−1 -> `count` unchanged. After 10 words (`DEPTH`=4), data arrives in order.
- Bundling: `SETUP_CYCLES`=3 -> `d_o` constant for ≥3 edges before each `r_o` rise and until the next pop. Assert `d_o` never changes while `r_o`=1 or `a_s`=1.
- Reset mid-REQ: assert `rst`=0 while `r_o`=1 -> `r_o`=0 with no clock edge needed, `count`=0. After release, new word 0x5 transfers normally.
